// File: rtl/frac_clk_bank.sv
// rtl/frac_clk_bank.sv - bank of fractional clock-enable generators (mul/div per channel)
// Optional FRAC_CLK_BANK_SYNC_EN adds a sync input that phase-aligns all running channels.
module frac_clk_bank #(
  parameter int CHANNELS     = 4,
  parameter int COUNTER_BITS = 8,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef FRAC_CLK_BANK_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [CHANNELS-1:0]     run,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [COUNTER_BITS-1:0] cfg_mul,
  input  logic [COUNTER_BITS-1:0] cfg_div,
  output logic                    cfg_err,
  output logic [CHANNELS-1:0]     en
);

  logic [COUNTER_BITS-1:0] mul_q [CHANNELS];
  logic [COUNTER_BITS-1:0] mul_d [CHANNELS];
  logic [COUNTER_BITS-1:0] div_q [CHANNELS];
  logic [COUNTER_BITS-1:0] div_d [CHANNELS];
  logic [COUNTER_BITS-1:0] acc_q [CHANNELS];
  logic [COUNTER_BITS-1:0] acc_d [CHANNELS];
  logic [CHANNELS-1:0]     en_q;
  logic [CHANNELS-1:0]     en_d;

  // Only one update can be outstanding because cfg_ready drops while it waits.
  logic                    pend_valid_q;
  logic                    pend_valid_d;
  logic [CH_W-1:0]         pend_ch_q;
  logic [CH_W-1:0]         pend_ch_d;
  logic [COUNTER_BITS-1:0] pend_mul_q;
  logic [COUNTER_BITS-1:0] pend_mul_d;
  logic [COUNTER_BITS-1:0] pend_div_q;
  logic [COUNTER_BITS-1:0] pend_div_d;
  logic                    cfg_err_q;
  logic                    cfg_err_d;

  logic [COUNTER_BITS:0]   sum [CHANNELS];
  logic [CHANNELS-1:0]     hit;
  logic                    sync_now;
  logic                    cfg_fire;
  logic                    cfg_bad;
  logic                    cfg_ok;
  logic                    pend_here;
  logic                    new_here;

  always_comb begin
`ifdef FRAC_CLK_BANK_SYNC_EN
    sync_now = sync;
`else
    sync_now = 1'b0;
`endif
    mul_d        = mul_q;
    div_d        = div_q;
    acc_d        = acc_q;
    en_d         = en_q;
    pend_valid_d = pend_valid_q;
    pend_ch_d    = pend_ch_q;
    pend_mul_d   = pend_mul_q;
    pend_div_d   = pend_div_q;
    pend_here    = 1'b0;
    new_here     = 1'b0;

    cfg_fire  = cfg_valid & ~pend_valid_q;
    cfg_bad   = (cfg_div == '0) || (cfg_mul > cfg_div) || (int'(cfg_ch) >= CHANNELS);
    cfg_err_d = cfg_fire & cfg_bad;
    cfg_ok    = cfg_fire & ~cfg_bad;

    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]    = {1'b0, acc_q[i]} + {1'b0, mul_q[i]};
      hit[i]    = (sum[i] >= {1'b0, div_q[i]});
      pend_here = pend_valid_q && (int'(pend_ch_q) == i);
      new_here  = cfg_ok && (int'(cfg_ch) == i);

      if (!run[i]) begin
        // A stopped channel restarts from phase 0 and takes new factors at once.
        acc_d[i] = '0;
        en_d[i]  = 1'b0;
        if (pend_here) begin
          mul_d[i]     = pend_mul_q;
          div_d[i]     = pend_div_q;
          pend_valid_d = 1'b0;
        end
        if (new_here) begin
          mul_d[i] = cfg_mul;
          div_d[i] = cfg_div;
        end
      end else begin
        if (sync_now) begin
          acc_d[i] = '0;
          en_d[i]  = 1'b0;
        end else if (hit[i]) begin
          acc_d[i] = COUNTER_BITS'(sum[i] - {1'b0, div_q[i]});
          en_d[i]  = 1'b1;
        end else begin
          acc_d[i] = sum[i][COUNTER_BITS-1:0];
          en_d[i]  = 1'b0;
        end
        // Swap factors on a pulse edge so no period is ever shortened.
        if (pend_here && (en_d[i] || (mul_q[i] == '0))) begin
          mul_d[i]     = pend_mul_q;
          div_d[i]     = pend_div_q;
          acc_d[i]     = '0;
          pend_valid_d = 1'b0;
        end
        if (new_here) begin
          pend_valid_d = 1'b1;
          pend_ch_d    = cfg_ch;
          pend_mul_d   = cfg_mul;
          pend_div_d   = cfg_div;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        mul_q[i] <= '0;
        div_q[i] <= COUNTER_BITS'(1);
        acc_q[i] <= '0;
      end
      en_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      pend_mul_q   <= '0;
      pend_div_q   <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mul_q[i] <= mul_d[i];
        div_q[i] <= div_d[i];
        acc_q[i] <= acc_d[i];
      end
      en_q         <= en_d;
      pend_valid_q <= pend_valid_d;
      pend_ch_q    <= pend_ch_d;
      pend_mul_q   <= pend_mul_d;
      pend_div_q   <= pend_div_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign cfg_ready = ~pend_valid_q;
  assign cfg_err   = cfg_err_q;
  assign en        = en_q;

endmodule

// File: tb/tb_frac_clk_bank.sv
// tb/tb_frac_clk_bank.sv - directed self-checking bench for frac_clk_bank
module tb_frac_clk_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync;
  logic [3:0] run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_mul;
  logic [7:0] cfg_div;
  logic       cfg_err;
  logic [3:0] en;

  int n_checks = 0;
  int n_err    = 0;
  int pulses;

  logic  exp_q[$];
  string tag_q[$];

  frac_clk_bank #(.CHANNELS(4), .COUNTER_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FRAC_CLK_BANK_SYNC_EN
    .sync      (sync),
`endif
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_mul   (cfg_mul),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .en        (en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drain(input int ch);
    logic  v;
    string t;
    while (exp_q.size() > 0) begin
      tick();
      v = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, {31'b0, en[ch]}, {31'b0, v});
    end
  endtask

  task automatic do_cfg(input int ch, input int m, input int d);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_mul   = 8'(m);
    cfg_div   = 8'(d);
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sync = 1'b0; run = '0;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_mul = '0; cfg_div = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_en", {28'b0, en}, 32'h0);
    check("reset_ready", {31'b0, cfg_ready}, 32'h1);
    check("reset_err", {31'b0, cfg_err}, 32'h0);

    // ch0 1/3: first pulse on 3rd edge, then every 3rd
    do_cfg(0, 1, 3);
    check("cfg_idle_ready", {31'b0, cfg_ready}, 32'h1);
    run[0] = 1'b1;
    for (int k = 0; k < 9; k++) push("ch0_div3", (k % 3) == 2);
    drain(0);

    // ch1 2/5: pattern 0,0,1,0,1 and 40 pulses per 100 cycles
    do_cfg(1, 2, 5);
    run[1] = 1'b1;
    for (int k = 0; k < 10; k++) push("ch1_pat", (k % 5 == 2) || (k % 5 == 4));
    drain(1);
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (en[1]) pulses++;
    end
    check("ch1_count100", pulses, 40);

    // ch2 4/4: always on, off one cycle after run drops
    do_cfg(2, 4, 4);
    run[2] = 1'b1;
    for (int k = 0; k < 5; k++) push("ch2_full", 1'b1);
    drain(2);
    run[2] = 1'b0;
    tick();
    check("ch2_stop", {31'b0, en[2]}, 32'h0);

    // rejected transfers
    do_cfg(2, 0, 0);
    check("rej_div0_err", {31'b0, cfg_err}, 32'h1);
    check("rej_div0_ready", {31'b0, cfg_ready}, 32'h1);
    tick();
    check("rej_err_clear", {31'b0, cfg_err}, 32'h0);
    do_cfg(1, 6, 5);
    check("rej_mulgt_err", {31'b0, cfg_err}, 32'h1);
    check("rej_mulgt_ready", {31'b0, cfg_ready}, 32'h1);
    tick();
    check("rej_err_clear2", {31'b0, cfg_err}, 32'h0);
    run[2] = 1'b1;
    for (int k = 0; k < 3; k++) push("ch2_unchanged", 1'b1);
    drain(2);
    run[2] = 1'b0;

    // glitch-free period change on ch0: 1/4 -> 1/2
    run[0] = 1'b0;
    tick();
    do_cfg(0, 1, 4);
    run[0] = 1'b1;
    push("ch0_div4", 1'b0); push("ch0_div4", 1'b0);
    push("ch0_div4", 1'b0); push("ch0_div4", 1'b1); push("ch0_div4", 1'b0);
    drain(0);
    do_cfg(0, 1, 2);
    check("pend_en", {31'b0, en[0]}, 32'h0);
    check("pend_ready", {31'b0, cfg_ready}, 32'h0);
    tick();
    check("pend_en2", {31'b0, en[0]}, 32'h0);
    check("pend_ready2", {31'b0, cfg_ready}, 32'h0);
    tick();
    check("apply_en", {31'b0, en[0]}, 32'h1);
    check("apply_ready", {31'b0, cfg_ready}, 32'h1);
    for (int k = 0; k < 4; k++) push("ch0_div2", (k % 2) == 1);
    drain(0);

    // reset discards a pending update
    do_cfg(0, 1, 5);
    check("pend2_ready", {31'b0, cfg_ready}, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_pend_ready", {31'b0, cfg_ready}, 32'h1);
    check("rst_pend_en", {28'b0, en}, 32'h0);
    for (int k = 0; k < 6; k++) push("ch0_after_rst", 1'b0);
    drain(0);

    // reset on a transfer edge discards the transfer
    run = '0;
    tick();
    reset = 1'b1;
    do_cfg(0, 1, 1);
    reset = 1'b0;
    check("rst_xfer_ready", {31'b0, cfg_ready}, 32'h1);
    run[0] = 1'b1;
    for (int k = 0; k < 3; k++) push("ch0_xfer_dropped", 1'b0);
    drain(0);

`ifdef FRAC_CLK_BANK_SYNC_EN
    run = '0;
    tick();
    for (int c = 0; c < 4; c++) do_cfg(c, 1, 3);
    for (int c = 0; c < 4; c++) begin
      run[c] = 1'b1;
      tick();
    end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_edge", {28'b0, en}, 32'h0);
    tick();
    check("sync_p1", {28'b0, en}, 32'h0);
    tick();
    check("sync_p2", {28'b0, en}, 32'h0);
    tick();
    check("sync_aligned", {28'b0, en}, 32'hf);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
